t_using_d_bank: RTL and testbench

T_USING_D_BANK -- requirements
Module: t_using_d_bank

---
 rtl/t_using_d_bank.sv | 84 ++++++++
 tb/tb_t_using_d_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/t_using_d_bank.sv
// Bank of WIDTH T-behaviour bits built from D flip-flops.
// Each bit updates as q ^ tog. The toggle vector comes from the per-bit request
// in mode 01, or from a ripple carry/borrow chain for count up/down.
// A synchronous load overrides the operation, and a synchronous active-low
// reset overrides everything. Every output except qb is registered.
module t_using_d_bank #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             busy
);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_UP     = 2'b10;
    localparam logic [1:0] MODE_DOWN   = 2'b11;

    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] next_q;
    logic             next_tc;
    logic             up_run;
    logic             dn_run;

    assign qb = ~q;

    // Toggle vector: per-bit request, or running AND of the lower q / qb bits
    always_comb begin
        tog    = '0;
        up_run = 1'b1;
        dn_run = 1'b1;
        unique case (mode)
            MODE_TOGGLE: tog = t;
            MODE_UP: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    tog[i] = up_run;
                    up_run = up_run & q[i];
                end
            end
            MODE_DOWN: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    tog[i] = dn_run;
                    dn_run = dn_run & qb[i];
                end
            end
            default: tog = '0;
        endcase
    end

    // Next-state selection (load over enable) and terminal-count detection
    always_comb begin
        next_q  = q;
        next_tc = 1'b0;
        if (load) begin
            next_q = d;
        end else if (en) begin
            next_q  = q ^ tog;
            next_tc = ((mode == MODE_UP)   && (&q)) ||
                      ((mode == MODE_DOWN) && (~|q));
        end
    end

    // State and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            q    <= '0;
            tc   <= 1'b0;
            busy <= 1'b0;
        end else begin
            q    <= next_q;
            tc   <= next_tc;
            busy <= (next_q != q);
        end
    end

endmodule

// File: tb/tb_t_using_d_bank.sv
// Directed-vector testbench for t_using_d_bank. The main instance uses
// WIDTH=8; a second instance with WIDTH=2 shares the control inputs so that
// back-to-back terminal counts can be observed.
module tb_t_using_d_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] t;
    logic       load;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] qb;
    logic       tc;
    logic       busy;

    logic [1:0] t2;
    logic [1:0] d2;
    logic [1:0] q2;
    logic [1:0] qb2;
    logic       tc2;
    logic       busy2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    t_using_d_bank #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load),
        .d(d), .q(q), .qb(qb), .tc(tc), .busy(busy)
    );

    t_using_d_bank #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t2), .load(load),
        .d(d2), .q(q2), .qb(qb2), .tc(tc2), .busy(busy2)
    );

    // One rising edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; load = 1'b1; d = 8'hA5; en = 1'b1; mode = 2'b10; t = 8'hFF;
        step();
        vectors++;
        if (q !== 8'h00 || qb !== 8'hFF || tc !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: q=%h qb=%h tc=%b busy=%b, want q=00 qb=FF tc=0 busy=0",
                     q, qb, tc, busy);
        end
    endtask

    task automatic test_count_up();
        logic [7:0] exp_q [4]  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic       exp_tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        rst = 1'b1; load = 1'b1; d = 8'hFD; en = 1'b0; mode = 2'b00;
        step();
        vectors++;
        if (q !== 8'hFD || busy !== 1'b1 || tc !== 1'b0) begin
            miscompares++;
            $display("FAIL up_load: q=%h busy=%b tc=%b, want FD 1 0", q, busy, tc);
        end
        load = 1'b0; en = 1'b1; mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (q !== exp_q[i] || tc !== exp_tc[i] || busy !== 1'b1 || qb !== ~exp_q[i]) begin
                miscompares++;
                $display("FAIL count_up[%0d]: q=%h qb=%h tc=%b busy=%b, want q=%h tc=%b busy=1",
                         i, q, qb, tc, busy, exp_q[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_count_down();
        logic [7:0] exp_q [3]  = '{8'h00, 8'hFF, 8'hFE};
        logic       exp_tc [3] = '{1'b0, 1'b1, 1'b0};
        load = 1'b1; d = 8'h01; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (q !== exp_q[i] || tc !== exp_tc[i]) begin
                miscompares++;
                $display("FAIL count_down[%0d]: q=%h tc=%b, want q=%h tc=%b",
                         i, q, tc, exp_q[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_toggle();
        load = 1'b1; d = 8'h0F; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; mode = 2'b01; t = 8'h3C;
        step();
        vectors++;
        if (q !== 8'h33 || busy !== 1'b1 || tc !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle: q=%h busy=%b tc=%b, want 33 1 0", q, busy, tc);
        end
        t = 8'h00;
        step();
        vectors++;
        if (q !== 8'h33 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle_zero: q=%h busy=%b, want 33 0", q, busy);
        end
        // Toggle-mode wrap from all-ones to zero must not raise tc
        load = 1'b1; d = 8'hFF;
        step();
        load = 1'b0; t = 8'hFF;
        step();
        vectors++;
        if (q !== 8'h00 || tc !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL toggle_wrap: q=%h tc=%b busy=%b, want 00 0 1", q, tc, busy);
        end
        // Mode 00 holds even with en=1
        mode = 2'b00; t = 8'hFF;
        step();
        vectors++;
        if (q !== 8'h00 || busy !== 1'b0 || tc !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_mode: q=%h busy=%b tc=%b, want 00 0 0", q, busy, tc);
        end
    endtask

    task automatic test_priority();
        load = 1'b1; d = 8'hFF; en = 1'b0;
        step();
        load = 1'b1; d = 8'h10; en = 1'b1; mode = 2'b10;
        step();
        vectors++;
        if (q !== 8'h10 || tc !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL load_over_count: q=%h tc=%b busy=%b, want 10 0 1", q, tc, busy);
        end
        en = 1'b0;
        step();
        vectors++;
        if (q !== 8'h10 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL load_same: q=%h busy=%b, want 10 0", q, busy);
        end
        // Loading the wrap value must not raise tc
        d = 8'h00; en = 1'b1; mode = 2'b10;
        step();
        vectors++;
        if (q !== 8'h00 || tc !== 1'b0) begin
            miscompares++;
            $display("FAIL load_wrap: q=%h tc=%b, want 00 0", q, tc);
        end
    endtask

    task automatic test_mode_change();
        // From 00: up -> 01, down -> 00, down -> FF with tc, each on the next edge
        logic [1:0] modes [3]  = '{2'b10, 2'b11, 2'b11};
        logic [7:0] exp_q [3]  = '{8'h01, 8'h00, 8'hFF};
        logic       exp_tc [3] = '{1'b0, 1'b0, 1'b1};
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mode = modes[i];
            step();
            vectors++;
            if (q !== exp_q[i] || tc !== exp_tc[i]) begin
                miscompares++;
                $display("FAIL mode_change[%0d]: q=%h tc=%b, want q=%h tc=%b",
                         i, q, tc, exp_q[i], exp_tc[i]);
            end
        end
    endtask

    task automatic test_mid_reset_gating();
        load = 1'b1; d = 8'h7E; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; mode = 2'b10;
        step();
        vectors++;
        if (q !== 8'h7F) begin
            miscompares++;
            $display("FAIL pre_reset_count: q=%h, want 7F", q);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (q !== 8'h00 || tc !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: q=%h tc=%b busy=%b, want 00 0 0", q, tc, busy);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (q !== 8'h01) begin
            miscompares++;
            $display("FAIL resume: q=%h, want 01", q);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (q !== 8'h01 || tc !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL gated[%0d]: q=%h tc=%b busy=%b, want 01 0 0", i, q, tc, busy);
            end
        end
    endtask

    task automatic test_async_pulse();
        // A reset pulse between edges must be ignored
        en = 1'b0; load = 1'b0;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        vectors++;
        if (q !== 8'h01) begin
            miscompares++;
            $display("FAIL async_immediate: q=%h, want 01", q);
        end
        step();
        vectors++;
        if (q !== 8'h01) begin
            miscompares++;
            $display("FAIL async_pulse: q=%h, want 01", q);
        end
    endtask

    task automatic test_back_to_back();
        // WIDTH=2 counting continuously: tc on every 4th edge
        logic [1:0] exp_q2 [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b0; load = 1'b0; en = 1'b0;
        step();
        rst = 1'b1; en = 1'b1; mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if (q2 !== exp_q2[i] || tc2 !== (exp_q2[i] == 2'd0)) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: q=%0d tc=%b, want q=%0d tc=%b",
                         i, q2, tc2, exp_q2[i], (exp_q2[i] == 2'd0));
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = 2'b00; t = '0; load = 1'b0; d = '0;
        t2 = '0; d2 = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_toggle();
        test_priority();
        test_mode_change();
        test_mid_reset_gating();
        test_async_pulse();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
